fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that owns the architectural fetch PC and drives the instruction memory port.
- Each cycle it presents its PC to the local branch predictor and takes back either pred_addr (the next PC) or, on a misprediction, recv_addr with br_hazard.
- Handles multi-cycle instruction-memory responses, buffers a fetched instruction while the pipeline is stalled, and squashes in-flight fetches on redirect.
- Produces the IF/ID load/flush controls shared by the IF/ID pipeline register and the predictor's IF/ID stage register.

Parameters:
RESET_PC, 32'h00000060, PC value loaded on reset.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
stall  input  1  global pipeline stall (IF/ID must not advance)
pred_addr  input  32  predicted next PC from branch predictor, combinational from pc
recv_addr  input  32  corrected PC on misprediction
br_hazard  input  1  misprediction detected in EX
imem_resp  input  1  instruction memory response valid
imem_rdata  input  32  instruction word, valid with imem_resp
pc  output  32  current fetch PC (predictor lookup index and tag)
imem_read  output  1  instruction read request
imem_address  output  32  instruction read address
instr_out  output  32  instruction delivered to IF/ID
pc_out  output  32  PC of instr_out
load_ifid  output  1  IF/ID register load enable
ifid_rst  output  1  IF/ID flush (bubble insert), applied together with load_ifid

Behaviour:
- Clock and reset: clk, rst; single clock domain; reset is synchronous and active-high.
- Redirect is qualified: redir = br_hazard & ~stall. br_hazard is ignored while stall=1, because the EX instruction has not advanced.
- Reset (sync, dominant): pc<=RESET_PC, state<=FETCH, buf<=0, redir_addr<=0.
- Outputs during the reset cycle: imem_read=0, load_ifid=0, ifid_rst=0, instr_out=0, pc_out=RESET_PC.
- Reset mid-request abandons the outstanding read; the next request is at RESET_PC.
- imem_address = pc at all times (the old pc in SQUASH). imem_read stays high and the address stays stable until imem_resp.
- pc_out = pc. instr_out = buf in HOLD, else imem_rdata.
- States: FETCH, HOLD, SQUASH.
- FETCH (imem_read=1):
  - redir: ifid_rst=1, load_ifid=1. If imem_resp, pc<=recv_addr and stay FETCH (response discarded). Else redir_addr<=recv_addr, go SQUASH.
  - imem_resp & ~stall: load_ifid=1, ifid_rst=0, pc<=pred_addr. Zero-bubble, one instruction per cycle on a hit.
  - imem_resp & stall: buf<=imem_rdata, go HOLD, load_ifid=0.
  - no resp & ~stall: load_ifid=1, ifid_rst=1 (bubble).
  - no resp & stall: load_ifid=0, ifid_rst=0.
- HOLD (imem_read=0; pc holds the buffered instruction's PC):
  - redir: discard buf, pc<=recv_addr, load_ifid=1, ifid_rst=1, go FETCH.
  - ~stall: load_ifid=1, ifid_rst=0, instr_out=buf, pc<=pred_addr, go FETCH.
  - stall: hold everything.
- SQUASH (imem_read=1, address = old pc; response is discarded):
  - Never delivers. When ~stall, load_ifid=1 and ifid_rst=1.
  - redir: redir_addr<=recv_addr (newest wins).
  - imem_resp: pc<=(redir ? recv_addr : redir_addr), go FETCH.
- pred_addr is sampled only in the cycle an instruction is delivered. The predictor's output is valid for the current pc.
- No wrap checks: pc arithmetic is done by the predictor; the PC is a full 32-bit value and wraps naturally.

Test Plan:
- Reset, then imem_resp=1 every cycle, stall=0, pred_addr=pc+4 -> imem_address 0x60, 0x64, 0x68 on consecutive cycles; load_ifid=1, ifid_rst=0 each cycle.
- Response latency 3 cycles, stall=0 -> two bubbles (load_ifid=1, ifid_rst=1), then delivery of 0x60 with pc_out=0x60.
- Response arrives with stall=1 for 2 cycles, imem_rdata=0x00A00093 -> HOLD, imem_read=0; when stall drops, instr_out=0x00A00093, load_ifid=1, pc advances to pred_addr.
- br_hazard=1, recv_addr=0x200, stall=0 while a 3-cycle fetch of 0x80 is outstanding -> SQUASH; address stays 0x80 until resp; data not delivered; next request at 0x200.
- br_hazard=1 with stall=1 for 2 cycles, then stall=0 -> redirect only in the stall=0 cycle; ifid_rst=1 exactly once.
- rst asserted while in HOLD with buf valid -> next cycle state FETCH, pc=0x60, buffered instruction never delivered.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns the fetch PC, drives the instruction memory
// port, buffers a returned instruction across stalls and squashes in-flight
// reads when EX redirects the front end.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pred_addr,
    input  logic [31:0] recv_addr,
    input  logic        br_hazard,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        load_ifid,
    output logic        ifid_rst
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic        redir;

    // A hazard only counts once EX has actually advanced.
    assign redir = br_hazard & ~stall;

    assign pc           = pc_q;
    assign imem_address = pc_q;

    // State, PC, holding buffer and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            redir_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    // Next-state logic and IF/ID controls; reset forces the port quiet.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_addr_d = redir_addr_q;
        imem_read    = 1'b0;
        load_ifid    = 1'b0;
        ifid_rst     = 1'b0;
        instr_out    = imem_rdata;
        pc_out       = pc_q;

        unique case (state_q)
            FETCH: begin
                imem_read = 1'b1;
                if (redir) begin
                    load_ifid = 1'b1;
                    ifid_rst  = 1'b1;
                    if (imem_resp) begin
                        pc_d = recv_addr;
                    end else begin
                        redir_addr_d = recv_addr;
                        state_d      = SQUASH;
                    end
                end else if (imem_resp && !stall) begin
                    load_ifid = 1'b1;
                    pc_d      = pred_addr;
                end else if (imem_resp) begin
                    buf_d   = imem_rdata;
                    state_d = HOLD;
                end else if (!stall) begin
                    load_ifid = 1'b1;
                    ifid_rst  = 1'b1;
                end
            end
            HOLD: begin
                instr_out = buf_q;
                if (redir) begin
                    load_ifid = 1'b1;
                    ifid_rst  = 1'b1;
                    pc_d      = recv_addr;
                    state_d   = FETCH;
                end else if (!stall) begin
                    load_ifid = 1'b1;
                    pc_d      = pred_addr;
                    state_d   = FETCH;
                end
            end
            SQUASH: begin
                // The read at the old pc must complete before the new one
                // can be issued; its data never reaches IF/ID.
                imem_read = 1'b1;
                if (!stall) begin
                    load_ifid = 1'b1;
                    ifid_rst  = 1'b1;
                end
                if (redir) begin
                    redir_addr_d = recv_addr;
                end
                if (imem_resp) begin
                    pc_d    = redir ? recv_addr : redir_addr_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (rst) begin
            imem_read = 1'b0;
            load_ifid = 1'b0;
            ifid_rst  = 1'b0;
            instr_out = '0;
            pc_out    = RESET_PC;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pred_addr;
    logic [31:0] recv_addr;
    logic        br_hazard;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        load_ifid;
    logic        ifid_rst;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.RESET_PC(32'h00000060)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pred_addr    (pred_addr),
        .recv_addr    (recv_addr),
        .br_hazard    (br_hazard),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .load_ifid    (load_ifid),
        .ifid_rst     (ifid_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        stall;
        logic        br;
        logic        resp;
        logic [31:0] pred;
        logic [31:0] recv;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcout;
        logic        ld;
        logic        fl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic chk, logic r, logic s, logic b, logic rs,
                                logic [31:0] pr, logic [31:0] rc, logic [31:0] rd_data,
                                logic rd, logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] pcout, logic ld, logic fl);
        vec_t v;
        v.chk = chk; v.rst = r; v.stall = s; v.br = b; v.resp = rs;
        v.pred = pr; v.recv = rc; v.rdata = rd_data;
        v.rd = rd; v.addr = addr; v.instr = instr; v.pcout = pcout;
        v.ld = ld; v.fl = fl;
        return v;
    endfunction

    task automatic drive(logic r, logic s, logic b, logic rs,
                         logic [31:0] pr, logic [31:0] rc, logic [31:0] dat);
        rst = r; stall = s; br_hazard = b; imem_resp = rs;
        pred_addr = pr; recv_addr = rc; imem_rdata = dat;
    endtask

    task automatic check(string name, logic [31:0] e_pc, logic e_rd,
                         logic [31:0] e_addr, logic [31:0] e_instr,
                         logic [31:0] e_pcout, logic e_ld, logic e_fl);
        checks++;
        if ({pc, imem_read, imem_address, instr_out, pc_out, load_ifid, ifid_rst} !==
            {e_pc, e_rd, e_addr, e_instr, e_pcout, e_ld, e_fl}) begin
            errors++;
            $display("FAIL %s: got pc=%h rd=%b addr=%h instr=%h pc_out=%h ld=%b fl=%b, want pc=%h rd=%b addr=%h instr=%h pc_out=%h ld=%b fl=%b",
                     name, pc, imem_read, imem_address, instr_out, pc_out, load_ifid, ifid_rst,
                     e_pc, e_rd, e_addr, e_instr, e_pcout, e_ld, e_fl);
        end
    endtask

    initial begin
        // chk rst stl br rsp pred recv rdata | rd addr instr pc_out ld fl
        // reset; pc is unknown in the very first cycle
        vecs.push_back(mk(0,1,0,0,0, 32'h0,   32'h0,   32'h0,        0,32'h60, 32'h0,       32'h60, 0,0));
        vecs.push_back(mk(1,1,0,0,1, 32'h0,   32'h0,   32'h11,       0,32'h60, 32'h0,       32'h60, 0,0));
        // back-to-back hits
        vecs.push_back(mk(1,0,0,0,1, 32'h64,  32'h0,   32'hA0,       1,32'h60, 32'hA0,      32'h60, 1,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h68,  32'h0,   32'hA1,       1,32'h64, 32'hA1,      32'h64, 1,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h6C,  32'h0,   32'hA2,       1,32'h68, 32'hA2,      32'h68, 1,0));
        // reset again (address still shows old pc), then 3-cycle latency
        vecs.push_back(mk(1,1,0,0,0, 32'h0,   32'h0,   32'h0,        0,32'h6C, 32'h0,       32'h60, 0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,   32'h0,   32'h0,        1,32'h60, 32'h0,       32'h60, 1,1));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,   32'h0,   32'h0,        1,32'h60, 32'h0,       32'h60, 1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h64,  32'h0,   32'hB0,       1,32'h60, 32'hB0,      32'h60, 1,0));
        // response under stall -> HOLD, release
        vecs.push_back(mk(1,0,1,0,1, 32'h68,  32'h0,   32'h00A00093, 1,32'h64, 32'h00A00093,32'h64, 0,0));
        vecs.push_back(mk(1,0,1,0,0, 32'h68,  32'h0,   32'hDEAD,     0,32'h64, 32'h00A00093,32'h64, 0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h68,  32'h0,   32'hDEAD,     0,32'h64, 32'h00A00093,32'h64, 1,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h80,  32'h0,   32'hC0,       1,32'h68, 32'hC0,      32'h68, 1,0));
        // redirect while fetch of 0x80 outstanding -> SQUASH
        vecs.push_back(mk(1,0,0,1,0, 32'h0,   32'h200, 32'h0,        1,32'h80, 32'h0,       32'h80, 1,1));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,   32'h0,   32'h0,        1,32'h80, 32'h0,       32'h80, 1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h0,   32'h0,   32'hD0,       1,32'h80, 32'hD0,      32'h80, 1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h204, 32'h0,   32'hE0,       1,32'h200,32'hE0,      32'h200,1,0));
        // hazard held under stall, acted on once stall drops (with resp)
        vecs.push_back(mk(1,0,1,1,0, 32'h0,   32'h300, 32'h0,        1,32'h204,32'h0,       32'h204,0,0));
        vecs.push_back(mk(1,0,1,1,0, 32'h0,   32'h300, 32'h0,        1,32'h204,32'h0,       32'h204,0,0));
        vecs.push_back(mk(1,0,0,1,1, 32'h0,   32'h300, 32'hF0,       1,32'h204,32'hF0,      32'h204,1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h304, 32'h0,   32'hF1,       1,32'h300,32'hF1,      32'h300,1,0));
        // reset while HOLD has a buffered instruction
        vecs.push_back(mk(1,0,1,0,1, 32'h308, 32'h0,   32'h12345678, 1,32'h304,32'h12345678,32'h304,0,0));
        vecs.push_back(mk(1,1,1,0,0, 32'h0,   32'h0,   32'h0,        0,32'h304,32'h0,       32'h60, 0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h999, 32'h0,   32'h0,        1,32'h60, 32'h0,       32'h60, 1,1));
        // redirect out of HOLD
        vecs.push_back(mk(1,0,1,0,1, 32'h64,  32'h0,   32'h77,       1,32'h60, 32'h77,      32'h60, 0,0));
        vecs.push_back(mk(1,0,0,1,0, 32'h64,  32'h400, 32'h0,        0,32'h60, 32'h77,      32'h60, 1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h404, 32'h0,   32'h88,       1,32'h400,32'h88,      32'h400,1,0));
        // SQUASH: stalled hazard ignored, newest unstalled redirect wins
        vecs.push_back(mk(1,0,0,1,0, 32'h0,   32'h500, 32'h0,        1,32'h404,32'h0,       32'h404,1,1));
        vecs.push_back(mk(1,0,1,1,0, 32'h0,   32'h600, 32'h0,        1,32'h404,32'h0,       32'h404,0,0));
        vecs.push_back(mk(1,0,0,1,0, 32'h0,   32'h700, 32'h0,        1,32'h404,32'h0,       32'h404,1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'h0,   32'h0,   32'h55,       1,32'h404,32'h55,      32'h404,1,1));
        vecs.push_back(mk(1,0,0,0,1, 32'hFFFFFFFC,32'h0,32'h99,      1,32'h700,32'h99,      32'h700,1,0));
        // natural wrap of the 32-bit pc
        vecs.push_back(mk(1,0,0,0,1, 32'h0,   32'h0,   32'h9A,       1,32'hFFFFFFFC,32'h9A, 32'hFFFFFFFC,1,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h4,   32'h0,   32'h9B,       1,32'h0,  32'h9B,      32'h0,  1,0));

        drive(1, 0, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].resp,
                  vecs[i].pred, vecs[i].recv, vecs[i].rdata);
            @(negedge clk);
            if (vecs[i].chk)
                check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].addr,
                      vecs[i].instr, vecs[i].pcout, vecs[i].ld, vecs[i].fl);
            @(posedge clk); #1;
        end

        // Slow memory: request must stay stable through a 5-cycle wait.
        drive(1, 0, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 32'h64, '0, 32'hBAD);
            @(negedge clk);
            check($sformatf("slow_wait%0d", k), 32'h60, 1'b1, 32'h60, 32'hBAD, 32'h60, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 1, 32'h64, '0, 32'h13);
        @(negedge clk);
        check("slow_deliver", 32'h60, 1'b1, 32'h60, 32'h13, 32'h60, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 32'h0, '0, 32'h0);
        @(negedge clk);
        check("slow_next", 32'h64, 1'b1, 32'h64, 32'h0, 32'h64, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
